jt6295_nibble_fetch: RTL and testbench
======================================

// Module: jt6295_nibble_fetch
// PURPOSE
//  Single-channel ADPCM sample fetcher, directly upstream of jt6295_adpcm.
//  Reads bytes from sample ROM between a start and a stop address and
//  emits one 4-bit nibble per sample strobe, high nibble first.
//  Drives the decoder's data/en pins. Signals completion to channel control.
//  A one-byte prefetch buffer hides ROM latency from the sample rate.
// PARAMETERS
//  AW   18   ROM byte-address width (MSM6295 space is 256 kB)
// PORTS
//  clk         in   1    system clock
//  rst         in   1    asynchronous, active-high reset
//  cen         in   1    sample strobe, one nibble consumed per cen
//  start       in   1    one-cycle pulse: begin playback
//  stop_req    in   1    one-cycle pulse: abort playback
//  start_addr  in   AW   first byte address, sampled on start
//  stop_addr   in   AW   last byte address (inclusive), sampled on start
//  rom_addr    out  AW   ROM byte address
//  rom_cs      out  1    ROM request
//  rom_data    in   8    ROM read data
//  rom_ok      in   1    ROM data valid for current rom_addr
//  nibble      out  4    ADPCM code to decoder data input
//  nibble_en   out  1    one-clk strobe: nibble valid, decoder advances
//  busy        out  1    channel playing (PRIME or PLAY)
//  done        out  1    one-clk pulse at end of playback or abort
//  underrun    out  1    sticky: cen arrived with no byte ready; cleared on start
// BEHAVIOUR
//  Reset: rom_addr=0, rom_cs=0, nibble=0, nibble_en=0, busy=0, done=0, underrun=0.
//   Both buffers are empty. FSM=IDLE.
//  Play FSM: IDLE -> PRIME -> PLAY -> IDLE.
//  - IDLE: on start, latch addresses, set fetch pointer = start_addr,
//    clear underrun, go to PRIME.
//  - PRIME: fetch the first byte. No nibble_en is issued. Go to PLAY on capture.
//  - PLAY, on cen:
//    - Current byte valid: emit byte[7:4], then on the next cen emit byte[3:0].
//    - After the low nibble, promote the prefetch byte to current.
//    - nibble_en pulses one clk in the cycle after cen.
//  - Current byte empty at cen: nibble_en stays low, nibble=0, underrun=1.
//  - After the low nibble of the byte at stop_addr: done=1 for one clk,
//    busy=0, go to IDLE.
//  Fetch side:
//  - Runs while busy and the prefetch slot is empty. The pointer stops after
//    stop_addr has been fetched.
//  - rom_cs=1 with rom_addr held stable until a qualified rom_ok.
//  - rom_ok is ignored in the first cycle after rom_addr changes, because
//    the ROM may report stale ok.
//  - Capture rom_data on a qualified ok. Then rom_cs=0 for 1 clk and the
//    pointer increments.
//  - Address wrap: pointer increments modulo 2^AW (3FFFF -> 0). Wrap is
//    legal when start_addr > stop_addr.
//  Boundary conditions:
//  - start_addr == stop_addr: exactly 2 nibbles, then done.
//  - start while busy: restart. Flush both buffers, drop rom_cs for 1 clk,
//    re-latch addresses, go to PRIME. No done pulse for the aborted run.
//  - stop_req while busy: flush, rom_cs=0, done pulse, IDLE. Ignored in IDLE.
//  - start and stop_req in the same cycle: start wins.
//  - cen coinciding with a capture: the captured byte goes to prefetch and
//    is not usable in that same cycle. Current-byte logic is unaffected.
//  - rst mid-fetch: immediate return to reset values. No ROM state is retained.
//  Latency:
//  - start -> rom_cs is 1 clk.
//  - First nibble_en follows the first cen after the PRIME capture.
// STRUCTURE
//  - Shared package jt6295_pkg:
//    - play-state encoding (IDLE/PRIME/PLAY)
//    - AW default
//    - nibble order constant (HI_FIRST).
//  - Sub-module jt6295_romreq: rom_cs/rom_addr hold, rom_ok qualification,
//    and capture strobe.
// TESTING
//  1. start=0x100, stop=0x101, ROM[100]=A5, [101]=3C, rom_ok 2 clk after cs
//     -> nibbles A,5,3,C on 4 cen, then done pulse, busy=0, no underrun.
//  2. start=stop=0x3FFFF, ROM=7E
//     -> nibbles 7,E, then done. rom_addr never reaches 0.
//  3. start=0x3FFFF, stop=0x00001
//     -> fetch order 3FFFF, 00000, 00001; 6 nibbles; done.
//  4. ROM latency 10 clk, cen every 4 clk
//     -> underrun=1 and missing nibble_en pulses. Data order is preserved.
//     Next start clears underrun.
//  5. stop_req after 3 nibbles
//     -> done pulse next clk, rom_cs=0, nibble_en silent until the next start.
//  6. start re-pulsed mid-play at 0x200 (ROM=91)
//     -> no done. The first nibble after restart is 9. rst mid-fetch
//     -> all outputs return to 0.

Source files
------------

// File: rtl/jt6295_pkg.sv
// rtl/jt6295_pkg.sv - shared play-state encoding, widths and nibble order for the jt6295 fetch path
package jt6295_pkg;

    localparam int AW_DEF = 18;
    localparam bit HI_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2
    } play_st_e;

    // second selects the later nibble of the byte in play order
    function automatic logic [3:0] pick_nibble(input logic [7:0] b, input logic second);
        return (second ^ ~HI_FIRST) ? b[3:0] : b[7:4];
    endfunction

endpackage

// File: rtl/jt6295_nibble_fetch_if.sv
// rtl/jt6295_nibble_fetch_if.sv - control, ROM and decoder-side signals of the nibble fetcher
interface jt6295_nibble_fetch_if
    import jt6295_pkg::*;
#(
    parameter int AW = AW_DEF
);
    logic          cen;
    logic          start;
    logic          stop_req;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] stop_addr;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic [3:0]    nibble;
    logic          nibble_en;
    logic          busy;
    logic          done;
    logic          underrun;

    modport master (
        input  cen, start, stop_req, start_addr, stop_addr, rom_data, rom_ok,
        output rom_addr, rom_cs, nibble, nibble_en, busy, done, underrun
    );

    modport slave (
        output cen, start, stop_req, start_addr, stop_addr, rom_data, rom_ok,
        input  rom_addr, rom_cs, nibble, nibble_en, busy, done, underrun
    );
endinterface

// File: rtl/jt6295_romreq.sv
// rtl/jt6295_romreq.sv - ROM request holder: keeps cs/addr stable and qualifies rom_ok
module jt6295_romreq
    import jt6295_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_i,
    input  logic [AW-1:0] issue_addr_i,
    input  logic          flush_i,
    input  logic          rom_ok_i,
    input  logic [7:0]    rom_data_i,
    output logic          rom_cs_o,
    output logic [AW-1:0] rom_addr_o,
    output logic          idle_o,
    output logic          cap_o,
    output logic [7:0]    cap_data_o
);
    logic          cs_q, cs_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          fresh_q, fresh_d;

    // the ROM may still report ok for the previous address in the first cycle
    assign cap_o      = cs_q & ~fresh_q & rom_ok_i & ~flush_i;
    assign cap_data_o = rom_data_i;
    assign rom_cs_o   = cs_q;
    assign rom_addr_o = addr_q;
    assign idle_o     = ~cs_q;

    always_comb begin
        cs_d    = cs_q;
        addr_d  = addr_q;
        fresh_d = 1'b0;
        if (flush_i) begin
            cs_d = 1'b0;
        end else if (issue_i) begin
            cs_d    = 1'b1;
            addr_d  = issue_addr_i;
            fresh_d = 1'b1;
        end else if (cap_o) begin
            cs_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q    <= 1'b0;
            addr_q  <= '0;
            fresh_q <= 1'b0;
        end else begin
            cs_q    <= cs_d;
            addr_q  <= addr_d;
            fresh_q <= fresh_d;
        end
    end

endmodule

// File: rtl/jt6295_nibble_fetch.sv
// rtl/jt6295_nibble_fetch.sv - single-channel ADPCM nibble fetcher feeding jt6295_adpcm
module jt6295_nibble_fetch
    import jt6295_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    jt6295_nibble_fetch_if.master bus
);
    play_st_e      state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] stop_q, stop_d;
    logic          more_q, more_d;
    logic [7:0]    cur_q, cur_d;
    logic          cur_v_q, cur_v_d;
    logic          cur_last_q, cur_last_d;
    logic          half_q, half_d;
    logic [7:0]    pref_q, pref_d;
    logic          pref_v_q, pref_v_d;
    logic          pref_last_q, pref_last_d;
    logic [3:0]    nib_q, nib_d;
    logic          nib_en_q, nib_en_d;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;

    logic          issue;
    logic [AW-1:0] issue_addr;
    logic          flush;
    logic          pop;
    logic          rq_idle;
    logic          cap;
    logic [7:0]    cap_data;
    logic          cap_last;

    jt6295_romreq #(.AW(AW)) u_romreq (
        .clk          (clk),
        .rst          (rst),
        .issue_i      (issue),
        .issue_addr_i (issue_addr),
        .flush_i      (flush),
        .rom_ok_i     (bus.rom_ok),
        .rom_data_i   (bus.rom_data),
        .rom_cs_o     (bus.rom_cs),
        .rom_addr_o   (bus.rom_addr),
        .idle_o       (rq_idle),
        .cap_o        (cap),
        .cap_data_o   (cap_data)
    );

    assign cap_last      = (ptr_q == stop_q);
    assign bus.nibble    = nib_q;
    assign bus.nibble_en = nib_en_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.underrun  = underrun_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        stop_d      = stop_q;
        more_d      = more_q;
        cur_d       = cur_q;
        cur_v_d     = cur_v_q;
        cur_last_d  = cur_last_q;
        half_d      = half_q;
        pref_d      = pref_q;
        pref_v_d    = pref_v_q;
        pref_last_d = pref_last_q;
        nib_d       = nib_q;
        nib_en_d    = 1'b0;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        issue       = 1'b0;
        issue_addr  = ptr_q;
        flush       = 1'b0;
        pop         = 1'b0;

        if (bus.start) begin
            // a restart drops cs for a cycle; PRIME then reissues from the new pointer
            state_d    = ST_PRIME;
            ptr_d      = bus.start_addr;
            stop_d     = bus.stop_addr;
            more_d     = 1'b1;
            underrun_d = 1'b0;
            cur_v_d    = 1'b0;
            pref_v_d   = 1'b0;
            half_d     = 1'b0;
            if (state_q == ST_IDLE) begin
                issue      = 1'b1;
                issue_addr = bus.start_addr;
            end else begin
                flush = 1'b1;
            end
        end else if (bus.stop_req && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            flush    = 1'b1;
            done_d   = 1'b1;
            more_d   = 1'b0;
            cur_v_d  = 1'b0;
            pref_v_d = 1'b0;
            half_d   = 1'b0;
        end else if (state_q != ST_IDLE) begin
            if (state_q == ST_PLAY && bus.cen) begin
                if (cur_v_q) begin
                    nib_en_d = 1'b1;
                    nib_d    = pick_nibble(cur_q, half_q);
                    if (half_q) pop = 1'b1;
                    else        half_d = 1'b1;
                end else begin
                    nib_d      = 4'd0;
                    underrun_d = 1'b1;
                end
            end

            if (pop) begin
                half_d      = 1'b0;
                cur_d       = pref_q;
                cur_v_d     = pref_v_q;
                cur_last_d  = pref_last_q;
                pref_v_d    = 1'b0;
                if (cur_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    more_d  = 1'b0;
                    flush   = 1'b1;
                    cur_v_d = 1'b0;
                end
            end

            // a byte captured now is only visible to cen from the next cycle on
            if (cap) begin
                if (cap_last) more_d = 1'b0;
                else          ptr_d  = ptr_q + AW'(1);
                if (!cur_v_d) begin
                    cur_d      = cap_data;
                    cur_v_d    = 1'b1;
                    cur_last_d = cap_last;
                end else begin
                    pref_d      = cap_data;
                    pref_v_d    = 1'b1;
                    pref_last_d = cap_last;
                end
                if (state_q == ST_PRIME) state_d = ST_PLAY;
            end

            if (more_q && rq_idle && !pref_v_q) begin
                issue      = 1'b1;
                issue_addr = ptr_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            stop_q      <= '0;
            more_q      <= 1'b0;
            cur_q       <= 8'd0;
            cur_v_q     <= 1'b0;
            cur_last_q  <= 1'b0;
            half_q      <= 1'b0;
            pref_q      <= 8'd0;
            pref_v_q    <= 1'b0;
            pref_last_q <= 1'b0;
            nib_q       <= 4'd0;
            nib_en_q    <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            stop_q      <= stop_d;
            more_q      <= more_d;
            cur_q       <= cur_d;
            cur_v_q     <= cur_v_d;
            cur_last_q  <= cur_last_d;
            half_q      <= half_d;
            pref_q      <= pref_d;
            pref_v_q    <= pref_v_d;
            pref_last_q <= pref_last_d;
            nib_q       <= nib_d;
            nib_en_q    <= nib_en_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_jt6295_nibble_fetch.sv
// tb/tb_jt6295_nibble_fetch.sv - directed bench for jt6295_nibble_fetch with a latency-configurable ROM
module tb_jt6295_nibble_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    jt6295_nibble_fetch_if #(.AW(18)) bus ();

    jt6295_nibble_fetch #(.AW(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] mem [int];
    int         lat      = 2;
    logic       stale_en = 1'b0;

    function automatic logic [7:0] rom_rd(input logic [17:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 8'h00;
    endfunction

    // ROM responder: ok after lat cycles at a stable address, optional stale ok on address change
    logic [17:0] prev_addr = '0;
    int          cnt       = 0;
    always @(negedge clk) begin
        logic chg;
        chg       = (bus.rom_addr != prev_addr);
        prev_addr = bus.rom_addr;
        if (!bus.rom_cs || chg) cnt = 0;
        else                    cnt++;
        if (bus.rom_cs && chg && stale_en) begin
            bus.rom_ok   = 1'b1;
            bus.rom_data = 8'hEE;
        end else begin
            bus.rom_ok   = bus.rom_cs && (cnt >= lat);
            bus.rom_data = rom_rd(bus.rom_addr);
        end
    end

    logic [3:0]  nibs [$];
    logic [17:0] fetches [$];
    int          done_cnt = 0;
    int          zero_cnt = 0;
    logic        cs_prev  = 1'b0;
    always @(negedge clk) begin
        if (bus.nibble_en) nibs.push_back(bus.nibble);
        if (bus.done) done_cnt++;
        if (bus.rom_cs && !cs_prev) fetches.push_back(bus.rom_addr);
        if (bus.rom_addr == 18'd0) zero_cnt++;
        cs_prev = bus.rom_cs;
    end

    function automatic logic [3:0] nib_at(input int i);
        return (i < nibs.size()) ? nibs[i] : 4'hx;
    endfunction

    function automatic logic [17:0] fetch_at(input int i);
        return (i < fetches.size()) ? fetches[i] : 18'hx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse(input logic [17:0] sa, input logic [17:0] ea);
        bus.start_addr = sa;
        bus.stop_addr  = ea;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic cen_pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.cen = 1'b1;
            @(negedge clk);
            bus.cen = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic check_nibs(input string tag, input int base, input logic [3:0] e0,
                              input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3);
        check({tag, "_n0"}, 32'(nib_at(base)),     32'(e0));
        check({tag, "_n1"}, 32'(nib_at(base + 1)), 32'(e1));
        check({tag, "_n2"}, 32'(nib_at(base + 2)), 32'(e2));
        check({tag, "_n3"}, 32'(nib_at(base + 3)), 32'(e3));
    endtask

    initial begin
        int nb, db, zb, fb, ncen;
        bus.cen        = 1'b0;
        bus.start      = 1'b0;
        bus.stop_req   = 1'b0;
        bus.start_addr = '0;
        bus.stop_addr  = '0;
        repeat (3) @(negedge clk);
        check("rst_rom_cs",    32'(bus.rom_cs),    32'd0);
        check("rst_rom_addr",  32'(bus.rom_addr),  32'd0);
        check("rst_nibble",    32'(bus.nibble),    32'd0);
        check("rst_nibble_en", 32'(bus.nibble_en), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_underrun",  32'(bus.underrun),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: two bytes, A5 3C
        mem[32'h100] = 8'hA5;
        mem[32'h101] = 8'h3C;
        lat = 2;
        nb = nibs.size(); db = done_cnt;
        start_pulse(18'h100, 18'h101);
        check("t1_cs_latency", 32'(bus.rom_cs), 32'd1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        repeat (6) @(negedge clk);
        cen_pulses(4, 8);
        repeat (2) @(negedge clk);
        check_nibs("t1", nb, 4'hA, 4'h5, 4'h3, 4'hC);
        check("t1_count", 32'(nibs.size() - nb), 32'd4);
        check("t1_done", 32'(done_cnt - db), 32'd1);
        check("t1_busy_end", 32'(bus.busy), 32'd0);
        check("t1_underrun", 32'(bus.underrun), 32'd0);

        // 2: single byte at the top of the address space
        mem[32'h3FFFF] = 8'h7E;
        nb = nibs.size(); db = done_cnt; zb = zero_cnt;
        start_pulse(18'h3FFFF, 18'h3FFFF);
        repeat (6) @(negedge clk);
        cen_pulses(2, 8);
        repeat (4) @(negedge clk);
        check("t2_n0", 32'(nib_at(nb)), 32'h7);
        check("t2_n1", 32'(nib_at(nb + 1)), 32'hE);
        check("t2_count", 32'(nibs.size() - nb), 32'd2);
        check("t2_done", 32'(done_cnt - db), 32'd1);
        check("t2_no_addr0", 32'(zero_cnt - zb), 32'd0);
        check("t2_rom_addr", 32'(bus.rom_addr), 32'h3FFFF);

        // 3: wrap from 3FFFF through 0 to 1
        mem[32'h0] = 8'h34;
        mem[32'h1] = 8'h56;
        nb = nibs.size(); db = done_cnt; fb = fetches.size();
        start_pulse(18'h3FFFF, 18'h00001);
        repeat (6) @(negedge clk);
        cen_pulses(6, 8);
        repeat (2) @(negedge clk);
        check("t3_f0", 32'(fetch_at(fb)),     32'h3FFFF);
        check("t3_f1", 32'(fetch_at(fb + 1)), 32'h00000);
        check("t3_f2", 32'(fetch_at(fb + 2)), 32'h00001);
        check_nibs("t3", nb, 4'h7, 4'hE, 4'h3, 4'h4);
        check("t3_n4", 32'(nib_at(nb + 4)), 32'h5);
        check("t3_n5", 32'(nib_at(nb + 5)), 32'h6);
        check("t3_done", 32'(done_cnt - db), 32'd1);

        // 4: slow ROM with stale ok, fast cen
        mem[32'h300] = 8'h9A;
        mem[32'h301] = 8'hBC;
        lat = 10; stale_en = 1'b1;
        nb = nibs.size(); db = done_cnt; ncen = 0;
        start_pulse(18'h300, 18'h301);
        for (int i = 0; i < 60 && done_cnt == db; i++) begin
            cen_pulses(1, 4);
            ncen++;
        end
        repeat (2) @(negedge clk);
        check("t4_underrun", 32'(bus.underrun), 32'd1);
        check_nibs("t4", nb, 4'h9, 4'hA, 4'hB, 4'hC);
        check("t4_count", 32'(nibs.size() - nb), 32'd4);
        check("t4_missing_en", 32'(ncen > 4), 32'd1);
        check("t4_done", 32'(done_cnt - db), 32'd1);
        stale_en = 1'b0; lat = 2;

        // 5: stop_req after three nibbles
        mem[32'h400] = 8'h11;
        mem[32'h401] = 8'h22;
        mem[32'h402] = 8'h33;
        nb = nibs.size(); db = done_cnt;
        start_pulse(18'h400, 18'h402);
        check("t5_underrun_clr", 32'(bus.underrun), 32'd0);
        repeat (6) @(negedge clk);
        cen_pulses(3, 8);
        bus.stop_req = 1'b1;
        @(negedge clk);
        bus.stop_req = 1'b0;
        check("t5_done", 32'(bus.done), 32'd1);
        check("t5_cs", 32'(bus.rom_cs), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("t5_done_1clk", 32'(bus.done), 32'd0);
        cen_pulses(3, 4);
        check("t5_silent", 32'(nibs.size() - nb), 32'd3);
        check("t5_n2", 32'(nib_at(nb + 2)), 32'h2);
        check("t5_done_cnt", 32'(done_cnt - db), 32'd1);

        // 6: restart mid-play, then reset mid-fetch
        mem[32'h500] = 8'h55;
        mem[32'h501] = 8'h66;
        mem[32'h502] = 8'h77;
        mem[32'h503] = 8'h88;
        mem[32'h200] = 8'h91;
        start_pulse(18'h500, 18'h503);
        repeat (6) @(negedge clk);
        cen_pulses(2, 8);
        nb = nibs.size(); db = done_cnt;
        start_pulse(18'h200, 18'h200);
        check("t6_cs_drop", 32'(bus.rom_cs), 32'd0);
        @(negedge clk);
        check("t6_cs_up", 32'(bus.rom_cs), 32'd1);
        check("t6_addr", 32'(bus.rom_addr), 32'h200);
        repeat (6) @(negedge clk);
        cen_pulses(2, 8);
        repeat (2) @(negedge clk);
        check("t6_n0", 32'(nib_at(nb)), 32'h9);
        check("t6_n1", 32'(nib_at(nb + 1)), 32'h1);
        check("t6_done", 32'(done_cnt - db), 32'd1);

        lat = 10;
        start_pulse(18'h600, 18'h601);
        repeat (2) @(negedge clk);
        check("t6_fetching", 32'(bus.rom_cs), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_cs",   32'(bus.rom_cs),   32'd0);
        check("t6_rst_addr", 32'(bus.rom_addr), 32'd0);
        check("t6_rst_busy", 32'(bus.busy),     32'd0);
        check("t6_rst_nib",  32'(bus.nibble),   32'd0);
        check("t6_rst_done", 32'(bus.done),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_post_cs",   32'(bus.rom_cs), 32'd0);
        check("t6_post_busy", 32'(bus.busy),   32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
